// File: rtl/jackpot_sequencer_if.sv
// jackpot_sequencer_if: switch/LED bundle between the jackpot controller (master) and the board (slave)
interface jackpot_sequencer_if;
  logic [3:0] SWITCHES;
  logic [3:0] LEDS;
  logic       WIN;
  logic [1:0] LEVEL;
  modport master (input SWITCHES, output LEDS, WIN, LEVEL);
  modport slave  (output SWITCHES, input LEDS, WIN, LEVEL);
endinterface

// File: rtl/jackpot_sequencer.sv
// jackpot_sequencer: single-clock 4-LED jackpot game (tick generator, switch sync/debounce, chase FSM).
// JACKPOT_DEBOUNCE_EN enables the per-switch debouncer; otherwise the synchronised switch is used directly.
module jackpot_sequencer #(
  parameter int TICK_DIV    = 26,
  parameter int DEB_BITS    = 20,
  parameter int FLASH_TICKS = 6
) (
  input logic CLOCK,
  input logic RST,
  jackpot_sequencer_if.master io
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_WIN = 2'd2, S_MISS = 2'd3;
  logic [3:0] sync1, sync2, deb, deb_q, press;
  logic [1:0] state, nstate, level, nlevel;
  logic [3:0] leds, nleds;
  logic [7:0] flash, nflash;
  logic [TICK_DIV-1:0] tcnt, tmask;
  logic win, tick;
  always_ff @(posedge CLOCK or negedge RST)
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= io.SWITCHES;
      sync2 <= sync1;
      deb_q <= deb;
    end
`ifdef JACKPOT_DEBOUNCE_EN
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [DEB_BITS-1:0] cnt;
    logic d;
    always_ff @(posedge CLOCK or negedge RST)
      if (!RST) begin
        cnt <= '0;
        d   <= 1'b0;
      end else if (sync2[i] == d) cnt <= '0;
      else if (&cnt) begin
        d   <= sync2[i];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign deb[i] = d;
  end
`else
  localparam int deb_unused = DEB_BITS;
  always_ff @(posedge CLOCK or negedge RST)
    if (!RST) deb <= '0;
    else deb <= sync2;
`endif
  assign press = deb & ~deb_q;
  // Higher levels ignore the top counter bits, halving the tick period per level
  assign tmask = {TICK_DIV{1'b1}} >> level;
  assign tick  = &(tcnt | ~tmask);
  always_comb begin
    nstate = state;
    nleds  = leds;
    nlevel = level;
    nflash = flash;
    case (state)
      S_IDLE: if (|press) begin
        nstate = S_RUN;
        nleds  = 4'b0001;
      end
      S_RUN: if (|press) begin
        nstate = (press == leds) ? S_WIN : S_MISS;
        nleds  = (press == leds) ? 4'b1111 : press;
        nflash = '0;
      end else if (tick) nleds = {leds[2:0], leds[3]};
      S_WIN: if (tick) begin
        nflash = flash + 8'd1;
        nstate = (nflash == 8'(FLASH_TICKS)) ? S_RUN : S_WIN;
        nleds  = (nflash == 8'(FLASH_TICKS)) ? 4'b0001 : ~leds;
        nlevel = (nflash != 8'(FLASH_TICKS)) ? level : (level == 2'd3) ? 2'd3 : level + 2'd1;
      end
      default: if (tick) begin
        nflash = flash + 8'd1;
        nstate = (nflash == 8'(FLASH_TICKS)) ? S_IDLE : S_MISS;
        nleds  = (nflash == 8'(FLASH_TICKS)) ? 4'b0000 : leds;
        nlevel = (nflash == 8'(FLASH_TICKS)) ? 2'd0 : level;
      end
    endcase
  end
  always_ff @(posedge CLOCK or negedge RST)
    if (!RST) begin
      state <= S_IDLE;
      leds  <= '0;
      level <= '0;
      flash <= '0;
      win   <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= nstate;
      leds  <= nleds;
      level <= nlevel;
      flash <= nflash;
      win   <= (nstate == S_WIN);
      tcnt  <= (nstate != state) ? '0 : tcnt + 1'b1;
    end
  assign io.LEDS  = leds;
  assign io.WIN   = win;
  assign io.LEVEL = level;
endmodule

// File: tb/tb_jackpot_sequencer.sv
// tb_jackpot_sequencer: directed game scenarios with TICK_DIV=5, DEB_BITS=2, FLASH_TICKS=2
module tb_jackpot_sequencer;
`ifdef JACKPOT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int LAT = DEB ? 6 : 3;
  logic CLOCK = 1'b0;
  logic RST = 1'b0;
  int errors = 0;
  int checks = 0;
  jackpot_sequencer_if bus ();
  jackpot_sequencer #(.TICK_DIV(5), .DEB_BITS(2), .FLASH_TICKS(2)) dut (
    .CLOCK(CLOCK),
    .RST(RST),
    .io(bus)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] leds, input logic w, input logic [1:0] lvl);
    checks++;
    assert ({bus.LEDS, bus.WIN, bus.LEVEL} === {leds, w, lvl}) else begin
      errors++;
      $error("FAIL %s: leds/win/level got %b/%b/%0d expected %b/%b/%0d",
             tag, bus.LEDS, bus.WIN, bus.LEVEL, leds, w, lvl);
    end
  endtask
  initial begin
    bus.SWITCHES = 4'b0000;
    step(3);
    chk("reset", 4'b0000, 0, 0);
    RST = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step(1);
      chk("idle", 4'b0000, 0, 0);
    end
    bus.SWITCHES = 4'b0100;
    step(LAT);
    chk("start_latency_pre", 4'b0000, 0, 0);
    step(1);
    chk("start", 4'b0001, 0, 0);
    step(4);
    bus.SWITCHES = 4'b0000;
    step(27);
    chk("chase_hold", 4'b0001, 0, 0);
    step(1);
    chk("chase_32", 4'b0010, 0, 0);
    step(31);
    chk("chase_hold2", 4'b0010, 0, 0);
    step(1);
    chk("chase_64", 4'b0100, 0, 0);
    step(32);
    chk("chase_96", 4'b1000, 0, 0);
    step(32);
    chk("chase_wrap", 4'b0001, 0, 0);
    step(32);
    chk("chase_160", 4'b0010, 0, 0);
    bus.SWITCHES = 4'b1010;
    step(LAT);
    chk("miss_pre", 4'b0010, 0, 0);
    step(1);
    chk("miss_enter", 4'b1010, 0, 0);
    bus.SWITCHES = 4'b0000;
    step(63);
    chk("miss_hold", 4'b1010, 0, 0);
    step(1);
    chk("miss_exit", 4'b0000, 0, 0);
    bus.SWITCHES = 4'b0001;
    step(3);
    bus.SWITCHES = 4'b0000;
    chk("glitch_pre", 4'b0000, 0, 0);
    step(1);
    chk("glitch_edge", DEB ? 4'b0000 : 4'b0001, 0, 0);
    step(20);
    chk("glitch_after", DEB ? 4'b0000 : 4'b0001, 0, 0);
    if (!DEB) begin
      bus.SWITCHES = 4'b1010;
      step(LAT + 1);
      bus.SWITCHES = 4'b0000;
      step(64);
    end
    chk("glitch_idle", 4'b0000, 0, 0);
    bus.SWITCHES = 4'b0100;
    step(LAT + 1);
    chk("restart", 4'b0001, 0, 0);
    bus.SWITCHES = 4'b0000;
    step(64);
    chk("win1_target", 4'b0100, 0, 0);
    bus.SWITCHES = 4'b0100;
    step(LAT);
    chk("win1_pre", 4'b0100, 0, 0);
    step(1);
    chk("win1_enter", 4'b1111, 1, 0);
    bus.SWITCHES = 4'b0000;
    step(31);
    chk("win1_hold", 4'b1111, 1, 0);
    step(1);
    chk("win1_toggle", 4'b0000, 1, 0);
    step(31);
    chk("win1_hold2", 4'b0000, 1, 0);
    step(1);
    chk("win1_exit", 4'b0001, 0, 1);
    step(15);
    chk("lvl1_hold", 4'b0001, 0, 1);
    step(1);
    chk("lvl1_16", 4'b0010, 0, 1);
    step(16);
    chk("lvl1_32", 4'b0100, 0, 1);
    bus.SWITCHES = 4'b0100;
    step(LAT);
    chk("win2_pre", 4'b0100, 0, 1);
    step(1);
    chk("win2_enter", 4'b1111, 1, 1);
    bus.SWITCHES = 4'b0000;
    step(15);
    chk("win2_hold", 4'b1111, 1, 1);
    step(1);
    chk("win2_toggle", 4'b0000, 1, 1);
    step(16);
    chk("win2_exit", 4'b0001, 0, 2);
    step(7);
    chk("lvl2_hold", 4'b0001, 0, 2);
    step(1);
    chk("lvl2_8", 4'b0010, 0, 2);
    step(8);
    chk("lvl2_16", 4'b0100, 0, 2);
    bus.SWITCHES = 4'b0100;
    step(LAT + 1);
    chk("win3_enter", 4'b1111, 1, 2);
    bus.SWITCHES = 4'b0000;
    step(3);
    RST = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 0, 0);
    @(posedge CLOCK);
    #1;
    RST = 1'b1;
    step(40);
    chk("post_reset_idle", 4'b0000, 0, 0);
    bus.SWITCHES = 4'b0001;
    step(LAT);
    chk("post_reset_pre", 4'b0000, 0, 0);
    step(1);
    chk("post_reset_start", 4'b0001, 0, 0);
    bus.SWITCHES = 4'b0000;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
